// File: rtl/bsa_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
//   state_e   : sequencer FSM states
//   lat_cnt_w : width of the adder-latency down-counter (at least 1)
//   idx_w     : width of the bit index
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // The counter only ever holds ADDER_LAT-1 down to 0.
  function automatic int lat_cnt_w(input int adder_lat);
    int w;
    w = $clog2(adder_lat);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int idx_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bsa_lat_counter.sv
// Loadable down-counter with terminal-count flag. Times the dwell between
// an adder issue and the cycle its result is valid.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (wins over en)
//   en         : count down, saturating at 0
//   load_val   : value loaded on load
//   tc         : counter is 0
module bsa_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/bit_serial_adder_sequencer.sv
// Drives a clocked one-bit adder cell as a WIDTH-bit serial adder.
// Operands arrive on in_* (valid/ready), one bit pair per issue slot goes
// out on adder_* LSB first with the returned carry chained into the next
// slot, and the assembled result leaves on out_* (valid/ready).
//   clk, rst_n             : clock, synchronous active-low reset
//   in_valid/in_ready      : operand handshake; in_a, in_b, in_cin
//   adder_strobe           : one-cycle issue pulse; adder_a/b/cin valid with it
//   adder_sum/adder_cout   : adder returns, ADDER_LAT clocks after issue
//   out_valid/out_ready    : result handshake; out_sum, out_cout
// Optional macro BSA_OVERFLOW_EN adds out_ovf (signed overflow flag).
module bit_serial_adder_sequencer
  import bsa_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDER_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             adder_a,
  output logic             adder_b,
  output logic             adder_cin,
  output logic             adder_strobe,
  input  logic             adder_sum,
  input  logic             adder_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef BSA_OVERFLOW_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int IW = idx_w(WIDTH);
  localparam int CW = lat_cnt_w(ADDER_LAT);

  state_e           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx, idx_nxt;
  logic             cnt_tc;
`ifdef BSA_OVERFLOW_EN
  logic             cmsb_q;
`endif

  assign idx_nxt = idx + IW'(1);

  bsa_lat_counter #(.W(CW)) u_lat (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ISSUE),
    .en       (state == WAIT),
    .load_val (CW'(ADDER_LAT - 1)),
    .tc       (cnt_tc)
  );

  // adder_* are registered and set on the transition into ISSUE, so the
  // issue pulse coincides with the ISSUE state. The carry register is
  // adder_cin itself: it is loaded from in_cin or the captured adder_cout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_cout     <= 1'b0;
      adder_strobe <= 1'b0;
      adder_a      <= 1'b0;
      adder_b      <= 1'b0;
      adder_cin    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      idx          <= '0;
`ifdef BSA_OVERFLOW_EN
      cmsb_q       <= 1'b0;
      out_ovf      <= 1'b0;
`endif
    end else begin
      adder_strobe <= 1'b0;
      adder_a      <= 1'b0;
      adder_b      <= 1'b0;
      adder_cin    <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          a_q          <= in_a;
          b_q          <= in_b;
          idx          <= '0;
          in_ready     <= 1'b0;
          adder_strobe <= 1'b1;
          adder_a      <= in_a[0];
          adder_b      <= in_b[0];
          adder_cin    <= in_cin;
          state        <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (cnt_tc) begin
          out_sum[idx] <= adder_sum;
          if (idx == IW'(WIDTH - 1)) begin
            out_cout  <= adder_cout;
            out_valid <= 1'b1;
`ifdef BSA_OVERFLOW_EN
            out_ovf   <= cmsb_q ^ adder_cout;
`endif
            state     <= DONE;
          end else begin
            idx          <= idx_nxt;
            adder_strobe <= 1'b1;
            adder_a      <= a_q[idx_nxt];
            adder_b      <= b_q[idx_nxt];
            adder_cin    <= adder_cout;
`ifdef BSA_OVERFLOW_EN
            // carry out of bit WIDTH-2 is the carry into the MSB
            if (idx == IW'(WIDTH - 2)) cmsb_q <= adder_cout;
`endif
            state        <= ISSUE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
